fifo_rd_stage: RTL and testbench
================================

FIFO_RD_STAGE -- requirements
Module: fifo_rd_stage

Interface
REQ-001 SHALL have parameter DataWidth, default 8, width of the FIFO read-data word.
REQ-002 SHALL have parameter CntWidth, default 16, width of the delivered-word counter.
REQ-003 SHALL have port rclk, input, 1, read-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port rrst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port rempty_i, input, 1, FIFO empty flag from the read-pointer/empty stage; high means rdata_i is not valid.
REQ-006 SHALL have port rdata_i, input, DataWidth, memory word at the current read pointer; valid whenever rempty_i is low.
REQ-007 SHALL have port rinc_o, output, 1, read-increment request to the read-pointer/empty stage.
REQ-008 SHALL have port m_valid_o, output, 1, downstream stream valid.
REQ-009 SHALL have port m_ready_i, input, 1, downstream stream ready.
REQ-010 SHALL have port m_data_o, output, DataWidth, downstream stream data.
REQ-011 SHALL have port rd_count_o, output, CntWidth, count of words delivered downstream.

Function
REQ-012 SHALL hold a 2-entry prefetch buffer (head, tail) with occupancy cnt in {0,1,2}; cnt is registered.
REQ-013 SHALL compute load = !rempty_i && (cnt < 2); rinc_o = load, combinational from rempty_i and registered cnt only (no path from m_ready_i).
REQ-014 SHALL never assert rinc_o while rempty_i is high.
REQ-015 SHALL capture rdata_i into the buffer on the rising edge at which load is high.
REQ-016 SHALL define pop = m_valid_o && m_ready_i; m_valid_o = (cnt != 0); m_data_o = head register.
REQ-017 SHALL apply cnt transitions: load only -> cnt+1; pop only -> cnt-1; both -> cnt unchanged; neither -> cnt unchanged.
REQ-018 SHALL, on load with cnt=0, write head; on load with cnt=1 and no pop, write tail.
REQ-019 SHALL, on load and pop with cnt=1, write the new word into head.
REQ-020 SHALL, on pop with cnt=2, move tail into head; load is impossible at cnt=2.
REQ-021 SHALL keep m_data_o stable while m_valid_o is high and m_ready_i is low.
REQ-022 SHALL have latency 1: a word with rempty_i low and cnt=0 at edge N appears on m_valid_o/m_data_o after edge N.
REQ-023 SHALL sustain one word per cycle when rempty_i stays low and m_ready_i stays high (cnt holds at 1).
REQ-024 SHALL increment rd_count_o by 1 on each pop and saturate at all-ones (no wrap).
REQ-025 SHALL preserve delivery order; no word is dropped or duplicated.

Reset
REQ-026 SHALL, while rrst_n is low, force cnt=0, m_valid_o=0, rinc_o=0, head=tail=0 (m_data_o=0), rd_count_o=0.
REQ-027 SHALL, on reset assertion mid-operation, discard buffered words immediately; first load is allowed on the first rising edge after release with rempty_i low.

Verification
REQ-028 SHALL cover reset: rrst_n low with rempty_i=0 -> rinc_o=0, m_valid_o=0, m_data_o=0, rd_count_o=0.
REQ-029 SHALL cover single word: rempty_i low one cycle with rdata_i=0xA5, m_ready_i=1 -> one rinc_o pulse, m_valid_o high one cycle next cycle with 0xA5, rd_count_o=1.
REQ-030 SHALL cover backpressure: m_ready_i=0, words 0x01,0x02,0x03 offered -> rinc_o for 0x01,0x02 only, then rinc_o=0 with cnt=2; raising m_ready_i delivers 0x01,0x02,0x03 in order.
REQ-031 SHALL cover streaming: rempty_i low 8 cycles with data 0x10..0x17, m_ready_i=1 -> 8 consecutive beats 0x10..0x17, rd_count_o=8.
REQ-032 SHALL cover simultaneous load/pop at cnt=1: head 0x20 popped while 0x21 loaded -> next m_data_o=0x21, cnt stays 1.
REQ-033 SHALL cover saturation and mid-stream reset: rd_count_o preloaded near all-ones saturates at 0xFFFF; rrst_n pulsed with cnt=2 -> m_valid_o=0 immediately, rd_count_o=0.

Source files
------------

// File: rtl/fifo_rd_stage.sv
// Read-side output stage of an async FIFO: 2-entry prefetch skid buffer feeding a
// valid/ready stream, plus a saturating count of words delivered downstream.
module fifo_rd_stage #(
  parameter int DataWidth = 8,
  parameter int CntWidth  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rempty_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 rinc_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic [CntWidth-1:0]  rd_count_o
);

  logic [1:0]           cnt_r;
  logic [DataWidth-1:0] head_r;
  logic [DataWidth-1:0] tail_r;
  logic [CntWidth-1:0]  count_r;
  logic                 load_s;
  logic                 pop_s;

  // Fetch whenever a slot is free; gated by reset so no read is requested while held in reset.
  always_comb begin
    load_s = rrst_n & ~rempty_i & (cnt_r != 2'd2);
    pop_s  = (cnt_r != 2'd0) & m_ready_i;
  end

  assign rinc_o     = load_s;
  assign m_valid_o  = (cnt_r != 2'd0);
  assign m_data_o   = head_r;
  assign rd_count_o = count_r;

  // Buffer occupancy and head/tail data movement.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_r  <= 2'd0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (cnt_r)
        2'd0: begin
          if (load_s) begin
            head_r <= rdata_i;
            cnt_r  <= 2'd1;
          end
        end
        2'd1: begin
          if (load_s && pop_s) begin
            head_r <= rdata_i;
          end else if (load_s) begin
            tail_r <= rdata_i;
            cnt_r  <= 2'd2;
          end else if (pop_s) begin
            cnt_r  <= 2'd0;
          end
        end
        2'd2: begin
          // Full: no load possible, a pop promotes tail.
          if (pop_s) begin
            head_r <= tail_r;
            cnt_r  <= 2'd1;
          end
        end
        default: begin
          cnt_r <= 2'd0;
        end
      endcase
    end
  end

  // Delivered-word counter, saturating at all-ones.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      count_r <= '0;
    end else if (pop_s && (count_r != {CntWidth{1'b1}})) begin
      count_r <= count_r + {{(CntWidth-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Bench for fifo_rd_stage: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_fifo_rd_stage;

  logic        rclk;
  logic        rrst_n;
  logic        rempty_i;
  logic [7:0]  rdata_i;
  logic        rinc_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [7:0]  m_data_o;
  logic [15:0] rd_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_rd_stage #(.DataWidth(8), .CntWidth(16)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rempty_i   (rempty_i),
    .rdata_i    (rdata_i),
    .rinc_o     (rinc_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .rd_count_o (rd_count_o)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic        rst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        ready;
    logic        e_rinc;
    logic        e_valid;
    logic        chk_d;
    logic [7:0]  e_data;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic rempty, input logic [7:0] d, input logic rdy);
    rrst_n    = rst;
    rempty_i  = rempty;
    rdata_i   = d;
    m_ready_i = rdy;
    #1;
  endtask

  // Reference model state
  logic [7:0] q[$];
  int         mcount;
  logic [7:0] src_next;
  logic       e_load;
  logic       e_valid;
  logic       r_empty;
  logic       r_ready;

  initial begin
    rrst_n = 1'b0; rempty_i = 1'b0; rdata_i = 8'hFF; m_ready_i = 1'b1;

    vecs[0]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[5]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16'd1};
    vecs[7]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 16'd1};
    vecs[8]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 16'd2};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 16'd3};
    vecs[10] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4};
    vecs[11] = '{1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd4};
    vecs[12] = '{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 16'd4};
    vecs[13] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 16'd5};
    vecs[14] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 16'd5};
    vecs[15] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd6};

    // Directed table: reset, single word, backpressure, simultaneous load/pop
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].rempty, vecs[i].rdata, vecs[i].ready);
      chk($sformatf("vec%0d_rinc", i), {31'd0, rinc_o}, {31'd0, vecs[i].e_rinc});
      chk($sformatf("vec%0d_valid", i), {31'd0, m_valid_o}, {31'd0, vecs[i].e_valid});
      if (vecs[i].chk_d)
        chk($sformatf("vec%0d_data", i), {24'd0, m_data_o}, {24'd0, vecs[i].e_data});
      chk($sformatf("vec%0d_count", i), {16'd0, rd_count_o}, {16'd0, vecs[i].e_count});
      tick();
    end

    // Streaming: 8 back-to-back words
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'h10 + 8'(i), 1'b1);
      chk("stream_rinc", {31'd0, rinc_o}, 32'd1);
      chk("stream_valid", {31'd0, m_valid_o}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("stream_data", {24'd0, m_data_o}, 32'h10 + 32'(i - 1));
      tick();
    end
    drive(1'b1, 1'b1, 8'h00, 1'b1);
    chk("stream_last_valid", {31'd0, m_valid_o}, 32'd1);
    chk("stream_last_data", {24'd0, m_data_o}, 32'h17);
    tick();
    chk("stream_count", {16'd0, rd_count_o}, 32'd8);
    chk("stream_drained", {31'd0, m_valid_o}, 32'd0);

    // Mid-stream reset with buffer full
    drive(1'b1, 1'b0, 8'h40, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h41, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h42, 1'b0);
    chk("full_rinc", {31'd0, rinc_o}, 32'd0);
    chk("full_data", {24'd0, m_data_o}, 32'h40);
    drive(1'b0, 1'b0, 8'h42, 1'b0);
    chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_data", {24'd0, m_data_o}, 32'd0);
    chk("rst_count", {16'd0, rd_count_o}, 32'd0);
    chk("rst_rinc", {31'd0, rinc_o}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    chk("post_rst_rinc", {31'd0, rinc_o}, 32'd1);
    tick();
    chk("post_rst_valid", {31'd0, m_valid_o}, 32'd1);
    chk("post_rst_data", {24'd0, m_data_o}, 32'h55);

    // Counter saturation: continuous stream, one pop per edge after the first
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h77, 1'b1);
    repeat (65535) tick();
    chk("sat_fffe", {16'd0, rd_count_o}, 32'hFFFE);
    tick();
    chk("sat_ffff", {16'd0, rd_count_o}, 32'hFFFF);
    repeat (4) tick();
    chk("sat_hold", {16'd0, rd_count_o}, 32'hFFFF);

    // Randomized traffic against the queue model
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    q.delete();
    mcount   = 0;
    src_next = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      r_empty = ($urandom_range(0, 3) == 0);
      r_ready = ($urandom_range(0, 2) != 0);
      drive(1'b1, r_empty, src_next, r_ready);
      e_load  = !r_empty && (q.size() < 2);
      e_valid = (q.size() > 0);
      chk("rnd_rinc", {31'd0, rinc_o}, {31'd0, e_load});
      chk("rnd_valid", {31'd0, m_valid_o}, {31'd0, e_valid});
      if (e_valid) chk("rnd_data", {24'd0, m_data_o}, {24'd0, q[0]});
      chk("rnd_count", {16'd0, rd_count_o}, 32'(mcount));
      tick();
      if (e_valid && r_ready) begin
        void'(q.pop_front());
        if (mcount < 65535) mcount++;
      end
      if (e_load) begin
        q.push_back(src_next);
        src_next = src_next + 8'd1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
